// File: rtl/button_debounce_filter_if.sv
// rtl/button_debounce_filter_if.sv - button debouncer bundle: raw buttons and sample wave in, clean levels and pulses out
interface button_debounce_filter_if #(
  parameter int WIDTH = 4
);
  logic             sample_clk;
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;
  logic             sample_tick;

  modport master (
    output sample_clk,
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sample_tick
  );

  modport slave (
    input  sample_clk,
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output sample_tick
  );
endinterface

// File: rtl/button_debounce_filter.sv
// rtl/button_debounce_filter.sv - multi-channel push-button debouncer sampled on rising edges of a slow divider wave
module button_debounce_filter #(
  parameter int WIDTH          = 4,
  parameter int STABLE_SAMPLES = 3,
  parameter bit ACTIVE_LOW     = 1
) (
  input logic                    clk,
  input logic                    reset,
  button_debounce_filter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE_LOW,
    CONFIRM_HIGH,
    IDLE_HIGH,
    CONFIRM_LOW
  } state_t;

  localparam logic [3:0]       LAST_CNT = 4'(STABLE_SAMPLES - 1);
  localparam logic [WIDTH-1:0] INACTIVE = {WIDTH{ACTIVE_LOW}};

  logic             s1, s2, s3;
  logic [WIDTH-1:0] b1, b2;
  logic [WIDTH-1:0] smp;
  logic             tick;

  // Buttons reset to their released level so nothing looks pressed right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      b1 <= INACTIVE;
      b2 <= INACTIVE;
    end else begin
      s1 <= bus.sample_clk;
      s2 <= s1;
      s3 <= s2;
      b1 <= bus.btn_in;
      b2 <= b1;
    end
  end

  assign tick = s2 & ~s3;
  assign smp  = ACTIVE_LOW ? ~b2 : b2;

  state_t           state [WIDTH];
  logic [3:0]       cnt   [WIDTH];
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE_LOW;
        cnt[i]   <= 4'd0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          case (state[i])
            IDLE_LOW: begin
              if (smp[i]) begin
                state[i] <= CONFIRM_HIGH;
                cnt[i]   <= 4'd1;
              end
            end
            CONFIRM_HIGH: begin
              if (!smp[i]) begin
                state[i] <= IDLE_LOW;
                cnt[i]   <= 4'd0;
              end else if (cnt[i] == LAST_CNT) begin
                state[i]   <= IDLE_HIGH;
                cnt[i]     <= 4'd0;
                level_q[i] <= 1'b1;
                press_q[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + 4'd1;
              end
            end
            IDLE_HIGH: begin
              if (!smp[i]) begin
                state[i] <= CONFIRM_LOW;
                cnt[i]   <= 4'd1;
              end
            end
            CONFIRM_LOW: begin
              if (smp[i]) begin
                state[i] <= IDLE_HIGH;
                cnt[i]   <= 4'd0;
              end else if (cnt[i] == LAST_CNT) begin
                state[i]     <= IDLE_LOW;
                cnt[i]       <= 4'd0;
                level_q[i]   <= 1'b0;
                release_q[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + 4'd1;
              end
            end
            default: begin
              state[i] <= IDLE_LOW;
              cnt[i]   <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.sample_tick = tick;
endmodule

// File: tb/tb_button_debounce_filter.sv
// tb/tb_button_debounce_filter.sv - self-checking bench for button_debounce_filter
module tb_button_debounce_filter;
  localparam int W  = 4;
  localparam int SS = 3;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  bit   freeze = 1'b0;
  bit   chk_en = 1'b1;

  button_debounce_filter_if #(.WIDTH(W)) bus ();

  button_debounce_filter #(
    .WIDTH(W),
    .STABLE_SAMPLES(SS),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.sample_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      if (!freeze) bus.sample_clk = ~bus.sample_clk;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a channel's level flips once its last SS tick samples all disagree with it.
  bit         sc_h [3];
  logic [3:0] in_h [2];
  logic [3:0] m_level = '0, m_press = '0, m_rel = '0, msmp;
  logic       m_tick = 1'b0;
  bit         mt;
  int         nd;
  bit         q [W][$];

  always @(posedge clk) begin
    if (reset) begin
      sc_h    = '{1'b0, 1'b0, 1'b0};
      in_h    = '{4'hF, 4'hF};
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_tick  = 1'b0;
      for (int i = 0; i < W; i++) q[i].delete();
    end else begin
      mt      = sc_h[1] & !sc_h[2];
      msmp    = ~in_h[1];
      m_press = '0;
      m_rel   = '0;
      if (mt) begin
        for (int i = 0; i < W; i++) begin
          q[i].push_back(msmp[i]);
          if (q[i].size() > SS) void'(q[i].pop_front());
          nd = 0;
          for (int j = 0; j < q[i].size(); j++) if (q[i][j] != m_level[i]) nd++;
          if (nd == SS) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) m_press[i] = 1'b1;
            else m_rel[i] = 1'b1;
          end
        end
      end
      sc_h[2] = sc_h[1];
      sc_h[1] = sc_h[0];
      sc_h[0] = bus.sample_clk;
      in_h[1] = in_h[0];
      in_h[0] = bus.btn_in;
      m_tick  = sc_h[1] & !sc_h[2];
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en)
      check("scoreboard", {bus.btn_level, bus.btn_press, bus.btn_release, bus.sample_tick},
            {m_level, m_press, m_rel, m_tick});
  end

  int press_cnt [W];
  int rel_cnt   [W];
  int tick_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      press_cnt[i] += int'(bus.btn_press[i]);
      rel_cnt[i]   += int'(bus.btn_release[i]);
    end
    tick_cnt += int'(bus.sample_tick);
  end

  task automatic next_tick();
    int n = 0;
    @(negedge clk);
    while (bus.sample_tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      $display("FAIL tick_timeout: no sample_tick within 20 cycles at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    bus.btn_in = v;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         ticks;
    logic [3:0] exp_level;
  } vec_t;

  vec_t vecs [8];
  int   p0, p1, t0, k;
  logic [3:0] v;

  initial begin
    for (int i = 0; i < W; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    bus.btn_in = 4'hF;
    vecs[0] = '{4'b1110, 2, 4'b0000};
    vecs[1] = '{4'b1110, 1, 4'b0001};
    vecs[2] = '{4'b1100, 3, 4'b0011};
    vecs[3] = '{4'b1111, 2, 4'b0011};
    vecs[4] = '{4'b1111, 1, 4'b0000};
    vecs[5] = '{4'b0101, 3, 4'b1010};
    vecs[6] = '{4'b1010, 3, 4'b0101};
    vecs[7] = '{4'b1111, 3, 4'b0000};

    // Reset / idle
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.btn_level, bus.btn_press, bus.btn_release, bus.sample_tick}, 13'd0);
    reset = 1'b0;
    t0 = tick_cnt;
    repeat (160) @(negedge clk);
    check("idle_tick_count", tick_cnt - t0, 20);
    check("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_level", bus.btn_level, 4'b0000);

    // Clean press then release on channel 0
    next_tick();
    drive(4'b1110);
    next_tick();
    next_tick();
    check("press_not_early", bus.btn_level, 4'b0000);
    p0 = press_cnt[0];
    next_tick();
    check("press_level", bus.btn_level[0], 1'b1);
    check("press_pulse", bus.btn_press[0], 1'b1);
    check("press_no_release", bus.btn_release[0], 1'b0);
    @(posedge clk);
    #1;
    check("press_width", bus.btn_press[0], 1'b0);
    drive(4'b1111);
    repeat (3) next_tick();
    check("release_level", bus.btn_level[0], 1'b0);
    check("release_pulse", bus.btn_release[0], 1'b1);
    repeat (3) @(negedge clk);
    check("press_once", press_cnt[0] - p0, 1);
    check("release_once", rel_cnt[0], 1);

    // Bounce on channel 1
    p1 = press_cnt[1];
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? 4'b1101 : 4'b1111);
      next_tick();
    end
    drive(4'b1101);
    check("bounce_no_press", press_cnt[1] - p1, 0);
    next_tick();
    next_tick();
    check("bounce_settle_early", bus.btn_level[1], 1'b0);
    next_tick();
    check("bounce_settle_press", {bus.btn_level[1], bus.btn_press[1]}, 2'b11);
    repeat (3) @(negedge clk);
    check("bounce_one_press", press_cnt[1] - p1, 1);

    // Glitch on channel 2 between ticks
    p0 = press_cnt[2];
    next_tick();
    v = bus.btn_in; v[2] = 1'b0; drive(v);
    @(negedge clk);
    v[2] = 1'b1; drive(v);
    repeat (4) next_tick();
    check("glitch_level", bus.btn_level[2], 1'b0);
    check("glitch_no_press", press_cnt[2] - p0, 0);

    // Reset during confirmation on channel 3
    next_tick();
    drive(4'b0111);
    next_tick();
    next_tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_outputs", {bus.btn_level, bus.btn_press, bus.btn_release}, 12'd0);
    reset = 1'b0;
    p0 = press_cnt[3];
    next_tick();
    check("midreset_tick1", bus.btn_level[3], 1'b0);
    next_tick();
    check("midreset_tick2", bus.btn_level[3], 1'b0);
    next_tick();
    check("midreset_tick3", {bus.btn_level[3], bus.btn_press[3]}, 2'b11);
    repeat (3) @(negedge clk);
    check("midreset_one_press", press_cnt[3] - p0, 1);

    // All channels at once
    drive(4'b1111);
    repeat (4) next_tick();
    check("simul_released", bus.btn_level, 4'b0000);
    drive(4'b0000);
    next_tick();
    next_tick();
    check("simul_not_early", bus.btn_level, 4'b0000);
    next_tick();
    check("simul_press", bus.btn_press, 4'b1111);
    check("simul_level", bus.btn_level, 4'b1111);
    @(posedge clk);
    #1;
    check("simul_press_width", bus.btn_press, 4'b0000);

    // Frozen sample wave
    freeze = 1'b1;
    repeat (10) @(negedge clk);
    t0 = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
    drive(4'b1111);
    repeat (60) @(negedge clk);
    check("freeze_level", bus.btn_level, 4'b1111);
    check("freeze_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - t0, 0);
    freeze = 1'b0;
    repeat (3) next_tick();
    check("unfreeze_release", bus.btn_level, 4'b0000);

    // Vector table
    next_tick();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].btn);
      repeat (vecs[i].ticks) next_tick();
      check($sformatf("vec%0d_level", i), bus.btn_level, vecs[i].exp_level);
    end

    // Randomised activity against the reference
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      k = $urandom_range(0, 15);
      if (k == 0) begin
        bus.btn_in = 4'($urandom);
      end else if (k == 1) begin
        v = bus.btn_in;
        k = $urandom_range(0, 3);
        v[k] = ~v[k];
        bus.btn_in = v;
      end
      if (c == 1200) reset = 1'b1;
      if (c == 1203) reset = 1'b0;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
